// File: rtl/sram_mem_controller_if.sv
// Bundle of the MEM-stage request/response signals and the external SRAM pins
// seen by sram_mem_controller. The controller uses the slave modport. The
// master modport is the pipeline/SRAM side, which also supplies sram_dq_in.
interface sram_mem_controller_if #(
    parameter int ADDR_W = 18
);
    logic              wr_en;
    logic              rd_en;
    logic [31:0]       address;
    logic [31:0]       write_data;
    logic              ready;
    logic [31:0]       read_data;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq_out;
    logic              sram_dq_oe;
    logic [15:0]       sram_dq_in;
    logic              sram_we_n;

    modport slave (
        input  wr_en, rd_en, address, write_data, sram_dq_in,
        output ready, read_data, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport master (
        output wr_en, rd_en, address, write_data, sram_dq_in,
        input  ready, read_data, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_mem_controller.sv
// MEM-stage data memory sequencer for an external 16-bit asynchronous SRAM.
// Each 32-bit load or store becomes two 16-bit halves, low then high. Each half
// lasts WAIT_CYCLES cycles. ready stays low (pipeline frozen) until the one-cycle
// DONE state. All SRAM pins are driven from registers.
// Optional feature: define SRAM_LAST_READ_CACHE_EN to add a one-entry tag. A
// repeated read of the last word read then completes in IDLE with no SRAM access.
module sram_mem_controller #(
    parameter int          ADDR_W      = 18,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst,
    sram_mem_controller_if.slave bus
);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Map a byte address to an SRAM word index. The offset from BASE_ADDR wraps
    // modulo 2^32. The low two address bits are dropped.
    function automatic logic [ADDR_W-2:0] map_word(input logic [31:0] addr);
        return (ADDR_W-1)'((addr - BASE_ADDR) >> 2);
    endfunction

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  counter_r, counter_s;
    logic [ADDR_W-2:0] word_r, word_s;
    logic [15:0]       wdata_hi_r, wdata_hi_s;
    logic              is_wr_r, is_wr_s;
    logic [ADDR_W-1:0] sram_addr_r, sram_addr_s;
    logic [15:0]       dq_out_r, dq_out_s;
    logic              dq_oe_r, dq_oe_s;
    logic              we_n_r, we_n_s;
    logic [31:0]       read_data_r, read_data_s;
    logic              req_s;
    logic              hit_s;
    logic [ADDR_W-2:0] req_word_s;

    assign req_s      = bus.rd_en | bus.wr_en;
    assign req_word_s = map_word(bus.address);

`ifdef SRAM_LAST_READ_CACHE_EN
    logic              valid_r, valid_s;
    logic [ADDR_W-2:0] tag_r, tag_s;

    // A pure read of the last word read is answered from read_data without an SRAM access.
    assign hit_s = (state_r == IDLE) && bus.rd_en && !bus.wr_en && valid_r && (tag_r == req_word_s);

    // Tag and valid bit of the most recent completed read.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            tag_r   <= '0;
        end else begin
            valid_r <= valid_s;
            tag_r   <= tag_s;
        end
    end
`else
    assign hit_s = 1'b0;
`endif

    assign bus.ready       = ((state_r == IDLE) && (!req_s || hit_s)) || (state_r == DONE);
    assign bus.read_data   = read_data_r;
    assign bus.sram_addr   = sram_addr_r;
    assign bus.sram_dq_out = dq_out_r;
    assign bus.sram_dq_oe  = dq_oe_r;
    assign bus.sram_we_n   = we_n_r;

    // Next state, and next values of the registered SRAM pins and read result.
    always_comb begin
        state_s     = state_r;
        counter_s   = counter_r;
        word_s      = word_r;
        wdata_hi_s  = wdata_hi_r;
        is_wr_s     = is_wr_r;
        sram_addr_s = sram_addr_r;
        dq_out_s    = dq_out_r;
        dq_oe_s     = dq_oe_r;
        we_n_s      = we_n_r;
        read_data_s = read_data_r;
`ifdef SRAM_LAST_READ_CACHE_EN
        valid_s     = valid_r;
        tag_s       = tag_r;
`endif
        case (state_r)
            IDLE: begin
                if (req_s && !hit_s) begin
                    state_s     = LO;
                    counter_s   = '0;
                    word_s      = req_word_s;
                    wdata_hi_s  = bus.write_data[31:16];
                    is_wr_s     = bus.wr_en;
                    sram_addr_s = {req_word_s, 1'b0};
                    we_n_s      = !bus.wr_en;
                    dq_oe_s     = bus.wr_en;
                    if (bus.wr_en) begin
                        dq_out_s = bus.write_data[15:0];
`ifdef SRAM_LAST_READ_CACHE_EN
                        valid_s  = 1'b0;
`endif
                    end else begin
                        dq_out_s = dq_out_r;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            LO: begin
                if (counter_r == LAST_CNT) begin
                    state_s     = HI;
                    counter_s   = '0;
                    sram_addr_s = {word_r, 1'b1};
                    if (is_wr_r) begin
                        dq_out_s = wdata_hi_r;
                    end else begin
                        read_data_s[15:0] = bus.sram_dq_in;
                    end
                end else begin
                    counter_s = counter_r + CNT_W'(1);
                end
            end
            HI: begin
                if (counter_r == LAST_CNT) begin
                    state_s   = DONE;
                    counter_s = '0;
                    we_n_s    = 1'b1;
                    dq_oe_s   = 1'b0;
                    if (!is_wr_r) begin
                        read_data_s[31:16] = bus.sram_dq_in;
`ifdef SRAM_LAST_READ_CACHE_EN
                        valid_s = 1'b1;
                        tag_s   = word_r;
`endif
                    end else begin
                        read_data_s = read_data_r;
                    end
                end else begin
                    counter_s = counter_r + CNT_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
                we_n_s  = 1'b1;
                dq_oe_s = 1'b0;
            end
            default: begin
                state_s = IDLE;
                we_n_s  = 1'b1;
                dq_oe_s = 1'b0;
            end
        endcase
    end

    // State register and registered SRAM pins. Reset aborts any access and releases the strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            counter_r   <= '0;
            word_r      <= '0;
            wdata_hi_r  <= 16'h0000;
            is_wr_r     <= 1'b0;
            sram_addr_r <= '0;
            dq_out_r    <= 16'h0000;
            dq_oe_r     <= 1'b0;
            we_n_r      <= 1'b1;
            read_data_r <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            counter_r   <= counter_s;
            word_r      <= word_s;
            wdata_hi_r  <= wdata_hi_s;
            is_wr_r     <= is_wr_s;
            sram_addr_r <= sram_addr_s;
            dq_out_r    <= dq_out_s;
            dq_oe_r     <= dq_oe_s;
            we_n_r      <= we_n_s;
            read_data_r <= read_data_s;
        end
    end
endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed, table-driven bench for sram_mem_controller with WAIT_CYCLES=2. A
// behavioural asynchronous SRAM answers reads combinationally. It stores a
// halfword on every clock edge where we_n is low.
module tb_sram_mem_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    sram_mem_controller_if #(.ADDR_W(18)) bus();

    sram_mem_controller #(
        .ADDR_W(18),
        .BASE_ADDR(32'd1024),
        .WAIT_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: 1024 halfwords, indexed by the low ten address bits.
    logic [15:0] mem [0:1023];
    assign bus.sram_dq_in = mem[bus.sram_addr[9:0]];

    // SRAM write: a halfword is stored on each clock edge with the strobe active.
    always @(posedge clk) begin
        if (!bus.sram_we_n) mem[bus.sram_addr[9:0]] <= bus.sram_dq_out;
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] lo_addr;
        logic [17:0] hi_addr;
        logic [15:0] lo_dq;
        logic [15:0] hi_dq;
        logic        exp_we_n;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [0:8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Run one full access: request in cycle 0, LO in cycles 1-2, HI in 3-4, DONE in 5.
    task automatic run_txn(input string tag, input vec_t v);
        @(posedge clk); #1;
        bus.wr_en      = v.wr;
        bus.rd_en      = v.rd;
        bus.address    = v.addr;
        bus.write_data = v.wdata;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("%s_c%0d_ready", tag, c), {31'd0, bus.ready}, {31'd0, (c == 5)});
            if (c >= 1 && c <= 4) begin
                check($sformatf("%s_c%0d_addr", tag, c), {14'd0, bus.sram_addr},
                      {14'd0, (c <= 2) ? v.lo_addr : v.hi_addr});
                check($sformatf("%s_c%0d_we_n", tag, c), {31'd0, bus.sram_we_n}, {31'd0, v.exp_we_n});
                check($sformatf("%s_c%0d_oe", tag, c), {31'd0, bus.sram_dq_oe}, {31'd0, !v.exp_we_n});
                if (!v.exp_we_n) begin
                    check($sformatf("%s_c%0d_dq", tag, c), {16'd0, bus.sram_dq_out},
                          {16'd0, (c <= 2) ? v.lo_dq : v.hi_dq});
                end
            end
            if (c == 5) begin
                check($sformatf("%s_done_rdata", tag), bus.read_data, v.exp_rd);
                check($sformatf("%s_done_we_n", tag), {31'd0, bus.sram_we_n}, 32'd1);
                check($sformatf("%s_done_oe", tag), {31'd0, bus.sram_dq_oe}, 32'd0);
            end
            if (c < 5) begin
                @(posedge clk); #1;
                if (c == 4) begin
                    bus.wr_en = 1'b0;
                    bus.rd_en = 1'b0;
                end
            end
        end
    endtask

    initial begin
        bus.wr_en      = 1'b0;
        bus.rd_en      = 1'b0;
        bus.address    = 32'h0000_0000;
        bus.write_data = 32'h0000_0000;

        //           wr    rd    addr          wdata          lo        hi        lo_dq     hi_dq     we_n  exp_rd
        vecs[0] = '{1'b1, 1'b0, 32'd1024,    32'h1234ABCD, 18'd0,     18'd1,     16'hABCD, 16'h1234, 1'b0, 32'h00000000};
        vecs[1] = '{1'b0, 1'b1, 32'd1024,    32'h00000000, 18'd0,     18'd1,     16'h0000, 16'h0000, 1'b1, 32'h1234ABCD};
        vecs[2] = '{1'b1, 1'b0, 32'd1032,    32'hCAFEF00D, 18'd4,     18'd5,     16'hF00D, 16'hCAFE, 1'b0, 32'h1234ABCD};
        vecs[3] = '{1'b0, 1'b1, 32'd1032,    32'h00000000, 18'd4,     18'd5,     16'h0000, 16'h0000, 1'b1, 32'hCAFEF00D};
        vecs[4] = '{1'b1, 1'b1, 32'd1028,    32'hFFFF0000, 18'd2,     18'd3,     16'h0000, 16'hFFFF, 1'b0, 32'hCAFEF00D};
        vecs[5] = '{1'b0, 1'b1, 32'd1030,    32'h00000000, 18'd2,     18'd3,     16'h0000, 16'h0000, 1'b1, 32'hFFFF0000};
        vecs[6] = '{1'b1, 1'b0, 32'd1020,    32'h5A5AA5A5, 18'h3FFFE, 18'h3FFFF, 16'hA5A5, 16'h5A5A, 1'b0, 32'hFFFF0000};
        vecs[7] = '{1'b0, 1'b1, 32'd1020,    32'h00000000, 18'h3FFFE, 18'h3FFFF, 16'h0000, 16'h0000, 1'b1, 32'h5A5AA5A5};
        vecs[8] = '{1'b0, 1'b1, 32'd1024,    32'h00000000, 18'd0,     18'd1,     16'h0000, 16'h0000, 1'b1, 32'h1234ABCD};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_we_n", {31'd0, bus.sram_we_n}, 32'd1);
        check("rst_oe", {31'd0, bus.sram_dq_oe}, 32'd0);
        check("rst_addr", {14'd0, bus.sram_addr}, 32'd0);
        check("rst_dq", {16'd0, bus.sram_dq_out}, 32'd0);
        check("rst_rdata", bus.read_data, 32'd0);
        rst = 1'b0;

        // Main table. Each access starts in the cycle right after the previous DONE.
        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("v%0d", i), vecs[i]);
        end

        // Idle after DONE: ready high, strobe released
        @(negedge clk);
        check("idle_ready", {31'd0, bus.ready}, 32'd1);
        check("idle_we_n", {31'd0, bus.sram_we_n}, 32'd1);

        // Reset in cycle 2 of a write
        @(posedge clk); #1;
        bus.wr_en      = 1'b1;
        bus.address    = 32'd1040;
        bus.write_data = 32'h11112222;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst       = 1'b1;
        bus.wr_en = 1'b0;
        @(negedge clk);
        check("abort_c2_we_n", {31'd0, bus.sram_we_n}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_we_n", {31'd0, bus.sram_we_n}, 32'd1);
        check("abort_oe", {31'd0, bus.sram_dq_oe}, 32'd0);
        check("abort_ready", {31'd0, bus.ready}, 32'd1);
        check("abort_rdata", bus.read_data, 32'd0);
        check("abort_addr", {14'd0, bus.sram_addr}, 32'd0);
        @(negedge clk);
        check("abort_idle_ready", {31'd0, bus.ready}, 32'd1);

`ifdef SRAM_LAST_READ_CACHE_EN
        // Fill the tag with a full read of 1024
        run_txn("c_fill", vecs[8]);
        // A repeated read hits: ready in cycle 0, no SRAM activity
        @(posedge clk); #1;
        bus.rd_en   = 1'b1;
        bus.address = 32'd1024;
        @(negedge clk);
        check("hit_ready", {31'd0, bus.ready}, 32'd1);
        check("hit_rdata", bus.read_data, 32'h1234ABCD);
        check("hit_we_n", {31'd0, bus.sram_we_n}, 32'd1);
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
        @(negedge clk);
        check("hit_addr_unchanged", {14'd0, bus.sram_addr}, 32'd1);
        check("hit_idle_ready", {31'd0, bus.ready}, 32'd1);
        // A write anywhere invalidates the entry; the next read takes the full path
        run_txn("c_wr2048", '{1'b1, 1'b0, 32'd2048, 32'h0BADBEEF, 18'd512, 18'd513,
                              16'hBEEF, 16'h0BAD, 1'b0, 32'h1234ABCD});
        run_txn("c_reread", vecs[8]);
        // Back-to-back miss to a different word starts LO right after DONE
        run_txn("c_b2b", vecs[3]);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
